// File: rtl/cdr_pkg.sv
// Shared types and defaults for the ZigBee clock/data recovery blocks.
package cdr_pkg;

    typedef enum logic [1:0] {PD_NONE, PD_EARLY, PD_LATE} pd_dec_t;

    localparam int CDR_OSR     = 25;
    localparam int CDR_DATA_PH = 12;

    function automatic pd_dec_t pd_classify(input logic t, input logic e);
        if (!t) begin
            return PD_NONE;
        end
        return e ? PD_EARLY : PD_LATE;
    endfunction

    function automatic logic signed [1:0] pd_step(input pd_dec_t dec);
        case (dec)
            PD_EARLY: return 2'sb01;
            PD_LATE:  return 2'sb11;
            default:  return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/pd_symbol_timer.sv
// Symbol-phase counter with one-deep advance/retard slip requests and
// edge/data sample strobes.
module pd_symbol_timer
    import cdr_pkg::*;
#(
    parameter int OSR     = CDR_OSR,
    parameter int DATA_PH = CDR_DATA_PH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic adv,
    input  logic ret,
    output logic edge_stb,
    output logic data_stb
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] ADV_PT   = CNT_W'(OSR - 2);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_PH);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             adv_reg, adv_next;
    logic             ret_reg, ret_next;
    logic             hold_reg, hold_next;

    always_comb begin
        cnt_next  = cnt_reg;
        adv_next  = adv_reg;
        ret_next  = ret_reg;
        hold_next = hold_reg;
        if (en) begin
            // hold_reg marks the second cycle spent at LAST during a retard
            if (cnt_reg == LAST && hold_reg) begin
                cnt_next  = '0;
                hold_next = 1'b0;
            end else if (adv_reg && ret_reg) begin
                if (cnt_reg == LAST) begin
                    cnt_next = '0;
                    adv_next = 1'b0;
                    ret_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end else if (adv_reg && cnt_reg == ADV_PT) begin
                cnt_next = '0;
                adv_next = 1'b0;
            end else if (ret_reg && cnt_reg == LAST) begin
                hold_next = 1'b1;
                ret_next  = 1'b0;
            end else if (cnt_reg == LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        // a new request wins over the clear of the same flag
        if (adv && !ret) begin
            adv_next = 1'b1;
        end
        if (ret && !adv) begin
            ret_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            adv_reg  <= 1'b0;
            ret_reg  <= 1'b0;
            hold_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            adv_reg  <= adv_next;
            ret_reg  <= ret_next;
            hold_reg <= hold_next;
        end
    end

    assign edge_stb = en && (cnt_reg == '0);
    assign data_stb = en && (cnt_reg == DATA_CNT);

endmodule

// File: rtl/alexander_pd_acc.sv
// Bang-bang (Alexander) phase detector with windowed error accumulation
// and lock detection for the CDR loop filter.
module alexander_pd_acc
    import cdr_pkg::*;
#(
    parameter int OSR     = CDR_OSR,
    parameter int DATA_PH = CDR_DATA_PH,
    parameter int WIN     = 16,
    parameter int ACC_W   = $clog2(WIN) + 2,
    parameter int LOCK_TH = 2,
    parameter int LOCK_N  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_dir,
    input  logic                    i_adv,
    input  logic                    i_ret,
    output logic                    o_T,
    output logic                    o_E,
    output logic                    o_pd_valid,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_acc_valid,
    output logic                    o_lock
);

    localparam int WC_W = (WIN > 2) ? $clog2(WIN) : 1;
    localparam int LK_W = $clog2(LOCK_N + 1);
    localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(LOCK_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;

    logic edge_stb, data_stb;

    pd_symbol_timer #(
        .OSR     (OSR),
        .DATA_PH (DATA_PH)
    ) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .en       (i_en),
        .adv      (i_adv),
        .ret      (i_ret),
        .edge_stb (edge_stb),
        .data_stb (data_stb)
    );

    logic                    e_reg, data_reg, primed_reg;
    logic                    t_reg, early_reg, pd_valid_reg, acc_valid_reg;
    logic signed [ACC_W-1:0] acc_reg, acc_out_reg, acc_sum;
    logic [WC_W-1:0]         win_cnt_reg;
    logic [LK_W-1:0]         lock_cnt_reg;
    logic                    t_new, e_new, in_lock;
    pd_dec_t                 dec;
    logic signed [1:0]       step;

    // data_reg holds the previous symbol's data; i_dir is the current one
    always_comb begin
        t_new   = data_reg ^ i_dir;
        e_new   = t_new & (e_reg ^ i_dir);
        dec     = pd_classify(t_new, e_new);
        step    = pd_step(dec);
        acc_sum = acc_reg + {{(ACC_W-2){step[1]}}, step};
        in_lock = (acc_out_reg <= TH_POS) && (acc_out_reg >= TH_NEG);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            e_reg         <= 1'b0;
            data_reg      <= 1'b0;
            primed_reg    <= 1'b0;
            t_reg         <= 1'b0;
            early_reg     <= 1'b0;
            pd_valid_reg  <= 1'b0;
            acc_valid_reg <= 1'b0;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            win_cnt_reg   <= '0;
            lock_cnt_reg  <= '0;
        end else begin
            pd_valid_reg  <= 1'b0;
            acc_valid_reg <= 1'b0;
            if (!i_en) begin
                primed_reg <= 1'b0;
            end
            if (edge_stb) begin
                e_reg <= i_dir;
            end
            if (data_stb) begin
                data_reg   <= i_dir;
                primed_reg <= 1'b1;
                if (primed_reg) begin
                    pd_valid_reg <= 1'b1;
                    t_reg        <= t_new;
                    early_reg    <= e_new;
                    if (win_cnt_reg == WC_W'(WIN - 1)) begin
                        acc_out_reg   <= acc_sum;
                        acc_valid_reg <= 1'b1;
                        acc_reg       <= '0;
                        win_cnt_reg   <= '0;
                    end else begin
                        acc_reg     <= acc_sum;
                        win_cnt_reg <= win_cnt_reg + WC_W'(1);
                    end
                end
            end
            // lock judges the window sum one cycle after it is reported
            if (acc_valid_reg) begin
                if (!in_lock) begin
                    lock_cnt_reg <= '0;
                end else if (lock_cnt_reg != LK_W'(LOCK_N)) begin
                    lock_cnt_reg <= lock_cnt_reg + LK_W'(1);
                end
            end
        end
    end

    assign o_T         = t_reg;
    assign o_E         = early_reg;
    assign o_pd_valid  = pd_valid_reg;
    assign o_acc       = acc_out_reg;
    assign o_acc_valid = acc_valid_reg;
    assign o_lock      = (lock_cnt_reg == LK_W'(LOCK_N));

endmodule
